// File: rtl/branch_predict_judge_if.sv
// Branch resolution / prediction bundle between the pipeline (master) and the judge (slave).
// Width parameters must match those of the attached branch_predict_judge.
interface branch_predict_judge_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 if_valid;
    logic [PC_WIDTH-1:0]  if_pc;
    logic                 pred_valid;
    logic                 pred_taken;
    logic                 ex_valid;
    logic [PC_WIDTH-1:0]  ex_pc;
    logic                 ex_branch;
    logic                 ex_jump;
    logic [2:0]           ex_cond;
    logic                 zero;
    logic                 positive;
    logic                 ex_pred_taken;
    logic                 out;
    logic                 mispredict;
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] mispredict_count;

    modport master (
        output if_valid, if_pc, ex_valid, ex_pc, ex_branch, ex_jump, ex_cond,
               zero, positive, ex_pred_taken,
        input  pred_valid, pred_taken, out, mispredict, branch_count, mispredict_count
    );

    modport slave (
        input  if_valid, if_pc, ex_valid, ex_pc, ex_branch, ex_jump, ex_cond,
               zero, positive, ex_pred_taken,
        output pred_valid, pred_taken, out, mispredict, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predict_judge.sv
// Resolves EX branches/jumps, keeps a PC-indexed table of 2-bit saturating counters
// for IF prediction, flags mispredictions and keeps saturating statistics.
module branch_predict_judge #(
    parameter int PC_WIDTH     = 32,
    parameter int ENTRIES      = 16,
    parameter int INDEX_LSB    = 2,
    parameter int PREDICT_MODE = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_predict_judge_if.slave  bp
);
    localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam bit DYNAMIC = (PREDICT_MODE != 0);

    logic [IDX_W-1:0]     if_idx;
    logic [IDX_W-1:0]     ex_idx;
    logic                 cond_res;
    logic                 resolve;
    logic                 taken;
    logic                 tbl_update;
    logic [ENTRIES-1:0]   entry_msb;

    logic                 pred_valid_q, pred_valid_d;
    logic                 pred_taken_q, pred_taken_d;
    logic                 out_q, out_d;
    logic                 mispredict_q, mispredict_d;
    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;

    assign if_idx = bp.if_pc[INDEX_LSB +: IDX_W];
    assign ex_idx = bp.ex_pc[INDEX_LSB +: IDX_W];

    always_comb begin
        cond_res = 1'b0;
        unique case (bp.ex_cond)
            3'b000: cond_res = bp.zero;
            3'b001: cond_res = !bp.zero;
            3'b010: cond_res = !bp.zero && !bp.positive;
            3'b011: cond_res = bp.zero || bp.positive;
            3'b100: cond_res = bp.positive;
            3'b101: cond_res = !bp.positive;
            3'b110: cond_res = 1'b1;
            3'b111: cond_res = 1'b0;
            default: cond_res = 1'b0;
        endcase
    end

    // A jump is always taken and wins over a simultaneously flagged branch.
    assign resolve    = bp.ex_valid && (bp.ex_jump || bp.ex_branch);
    assign taken      = bp.ex_jump || cond_res;
    assign tbl_update = DYNAMIC && bp.ex_valid && bp.ex_branch && !bp.ex_jump;

    // Counters live in flops so every entry can return to weakly-not-taken in one cycle.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_bht
            logic [1:0] ctr_q, ctr_d;

            always_comb begin
                ctr_d = ctr_q;
                if (tbl_update && (ex_idx == IDX_W'(gi))) begin
                    if (taken && (ctr_q != 2'b11)) begin
                        ctr_d = ctr_q + 2'b01;
                    end else if (!taken && (ctr_q != 2'b00)) begin
                        ctr_d = ctr_q - 2'b01;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ctr_q <= 2'b01;
                end else begin
                    ctr_q <= ctr_d;
                end
            end

            assign entry_msb[gi] = ctr_q[1];
        end
    endgenerate

    always_comb begin
        pred_valid_d     = bp.if_valid;
        pred_taken_d     = pred_taken_q;
        out_d            = resolve && taken;
        mispredict_d     = resolve && (taken != bp.ex_pred_taken);
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        // Lookup samples the pre-update counter, so a same-cycle update is not visible yet.
        if (bp.if_valid) begin
            pred_taken_d = DYNAMIC ? entry_msb[if_idx] : 1'b0;
        end
        if (resolve && (branch_cnt_q != {CNT_WIDTH{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
        end
        if (mispredict_d && (mispredict_cnt_q != {CNT_WIDTH{1'b1}})) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_valid_q     <= 1'b0;
            pred_taken_q     <= 1'b0;
            out_q            <= 1'b0;
            mispredict_q     <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            pred_valid_q     <= pred_valid_d;
            pred_taken_q     <= pred_taken_d;
            out_q            <= out_d;
            mispredict_q     <= mispredict_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign bp.pred_valid       = pred_valid_q;
    assign bp.pred_taken       = pred_taken_q;
    assign bp.out              = out_q;
    assign bp.mispredict       = mispredict_q;
    assign bp.branch_count     = branch_cnt_q;
    assign bp.mispredict_count = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predict_judge.sv
// Scoreboarded bench: a dynamic and a static judge share stimulus; a reference model
// pushes per-cycle expectations that a separate monitor pops and compares.
module tb_branch_predict_judge;
    localparam int PCW  = 32;
    localparam int ENT  = 16;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic        rst_n;
        logic        if_valid;
        logic [31:0] if_pc;
        logic        ex_valid;
        logic [31:0] ex_pc;
        logic        ex_branch;
        logic        ex_jump;
        logic [2:0]  cond;
        int          sign;     // -1, 0, +1 : sign of the compared operand
        logic        ex_pred;
    } stim_t;

    typedef struct {
        int pv;
        int pt;
        int o;
        int mp;
        int bc;
        int mc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_branch = 1'b0;
    logic        ex_jump = 1'b0;
    logic [2:0]  ex_cond = '0;
    logic        zero = 1'b0;
    logic        positive = 1'b0;
    logic        ex_pred_taken = 1'b0;

    branch_predict_judge_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CW)) bp_a ();
    branch_predict_judge_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CW)) bp_s ();

    assign bp_a.if_valid = if_valid;        assign bp_s.if_valid = if_valid;
    assign bp_a.if_pc = if_pc;              assign bp_s.if_pc = if_pc;
    assign bp_a.ex_valid = ex_valid;        assign bp_s.ex_valid = ex_valid;
    assign bp_a.ex_pc = ex_pc;              assign bp_s.ex_pc = ex_pc;
    assign bp_a.ex_branch = ex_branch;      assign bp_s.ex_branch = ex_branch;
    assign bp_a.ex_jump = ex_jump;          assign bp_s.ex_jump = ex_jump;
    assign bp_a.ex_cond = ex_cond;          assign bp_s.ex_cond = ex_cond;
    assign bp_a.zero = zero;                assign bp_s.zero = zero;
    assign bp_a.positive = positive;        assign bp_s.positive = positive;
    assign bp_a.ex_pred_taken = ex_pred_taken;
    assign bp_s.ex_pred_taken = ex_pred_taken;

    branch_predict_judge #(.PC_WIDTH(PCW), .ENTRIES(ENT), .INDEX_LSB(2),
                           .PREDICT_MODE(1), .CNT_WIDTH(CW))
        dut_dyn (.clk(clk), .rst_n(rst_n), .bp(bp_a.slave));

    branch_predict_judge #(.PC_WIDTH(PCW), .ENTRIES(ENT), .INDEX_LSB(2),
                           .PREDICT_MODE(0), .CNT_WIDTH(CW))
        dut_sta (.clk(clk), .rst_n(rst_n), .bp(bp_s.slave));

    // Reference model state
    int   m_tbl [ENT];
    int   m_pt;
    int   m_bc;
    int   m_mc;
    exp_t exp_q [$];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input int got, input int want);
        total_cnt++;
        if (got == want) pass_cnt++;
        else $display("FAIL %s got=%0d expected=%0d", name, got, want);
    endtask

    function automatic int tbl_idx(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    // Branch conditions read as comparisons of a signed operand against zero.
    function automatic int cond_taken(input logic [2:0] c, input int v);
        case (c)
            3'd0: return int'(v == 0);
            3'd1: return int'(v != 0);
            3'd2: return int'(v < 0);
            3'd3: return int'(v >= 0);
            3'd4: return int'(v > 0);
            3'd5: return int'(v <= 0);
            3'd6: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1; s.if_valid = 1'b0; s.if_pc = '0; s.ex_valid = 1'b0;
        s.ex_pc = '0; s.ex_branch = 1'b0; s.ex_jump = 1'b0; s.cond = '0;
        s.sign = 0; s.ex_pred = 1'b0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        int   tk;
        int   res;
        @(negedge clk);
        rst_n = s.rst_n; if_valid = s.if_valid; if_pc = s.if_pc;
        ex_valid = s.ex_valid; ex_pc = s.ex_pc; ex_branch = s.ex_branch;
        ex_jump = s.ex_jump; ex_cond = s.cond; ex_pred_taken = s.ex_pred;
        zero = (s.sign == 0); positive = (s.sign > 0);
        if (!s.rst_n) begin
            foreach (m_tbl[i]) m_tbl[i] = 1;
            m_pt = 0; m_bc = 0; m_mc = 0;
            e = '{pv: 0, pt: 0, o: 0, mp: 0, bc: 0, mc: 0};
        end else begin
            if (s.if_valid) m_pt = (m_tbl[tbl_idx(s.if_pc)] >= 2) ? 1 : 0;
            res = int'(s.ex_valid && (s.ex_jump || s.ex_branch));
            tk  = s.ex_jump ? 1 : cond_taken(s.cond, s.sign);
            e.pv = int'(s.if_valid);
            e.pt = m_pt;
            e.o  = res & tk;
            e.mp = res & int'(tk != int'(s.ex_pred));
            if (res != 0 && m_bc < CMAX) m_bc++;
            if (e.mp != 0 && m_mc < CMAX) m_mc++;
            e.bc = m_bc;
            e.mc = m_mc;
            if (s.ex_valid && s.ex_branch && !s.ex_jump) begin
                if (tk != 0) m_tbl[tbl_idx(s.ex_pc)] = (m_tbl[tbl_idx(s.ex_pc)] == 3) ? 3 : m_tbl[tbl_idx(s.ex_pc)] + 1;
                else         m_tbl[tbl_idx(s.ex_pc)] = (m_tbl[tbl_idx(s.ex_pc)] == 0) ? 0 : m_tbl[tbl_idx(s.ex_pc)] - 1;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dyn.pred_valid", int'(bp_a.pred_valid), e.pv);
            chk("dyn.pred_taken", int'(bp_a.pred_taken), e.pt);
            chk("dyn.out", int'(bp_a.out), e.o);
            chk("dyn.mispredict", int'(bp_a.mispredict), e.mp);
            chk("dyn.branch_count", int'(bp_a.branch_count), e.bc);
            chk("dyn.mispredict_count", int'(bp_a.mispredict_count), e.mc);
            chk("sta.pred_valid", int'(bp_s.pred_valid), e.pv);
            chk("sta.pred_taken", int'(bp_s.pred_taken), 0);
            chk("sta.out", int'(bp_s.out), e.o);
            chk("sta.mispredict", int'(bp_s.mispredict), e.mp);
            chk("sta.branch_count", int'(bp_s.branch_count), e.bc);
            chk("sta.mispredict_count", int'(bp_s.mispredict_count), e.mc);
        end
    end

    task automatic do_reset(input int cycles);
        stim_t s;
        s = idle();
        s.rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) drive(s);
    endtask

    task automatic lookup(input logic [31:0] pc);
        stim_t s;
        s = idle();
        s.if_valid = 1'b1; s.if_pc = pc;
        drive(s);
    endtask

    task automatic branch(input logic [31:0] pc, input logic [2:0] c, input int sgn,
                          input logic pred);
        stim_t s;
        s = idle();
        s.ex_valid = 1'b1; s.ex_pc = pc; s.ex_branch = 1'b1; s.cond = c;
        s.sign = sgn; s.ex_pred = pred;
        drive(s);
    endtask

    initial begin
        stim_t s;
        int    signs [3];
        signs[0] = 0; signs[1] = 1; signs[2] = -1;

        do_reset(2);
        // Every entry starts weakly not-taken
        lookup(32'h40);
        for (int i = 0; i < ENT; i++) lookup(32'(i) << 2);

        // Three taken EQ branches walk an entry up to strongly taken
        for (int i = 0; i < 3; i++) branch(32'h40, 3'd0, 0, 1'b0);
        lookup(32'h40);

        // Condition sweep
        for (int c = 0; c < 8; c++)
            for (int k = 0; k < 3; k++)
                branch(32'h104, 3'(c), signs[k], 1'($urandom_range(0, 1)));
        drive(idle());

        // Jump wins over branch and leaves the table alone
        do_reset(1);
        s = idle();
        s.ex_valid = 1'b1; s.ex_pc = 32'h44; s.ex_branch = 1'b1; s.ex_jump = 1'b1;
        s.cond = 3'd7; s.ex_pred = 1'b1;
        drive(s);
        lookup(32'h44);

        // Same-cycle lookup and update of index 5 returns the old value
        do_reset(1);
        s = idle();
        s.if_valid = 1'b1; s.if_pc = 32'h14;
        s.ex_valid = 1'b1; s.ex_pc = 32'h14; s.ex_branch = 1'b1; s.cond = 3'd6;
        drive(s);
        lookup(32'h14);

        // Saturation of the statistics counters
        for (int i = 0; i < 20; i++) branch(32'h20, 3'd6, 0, 1'b0);
        lookup(32'h20);
        // Reset wins over a branch resolving on the same edge
        s = idle();
        s.rst_n = 1'b0; s.ex_valid = 1'b1; s.ex_pc = 32'h20; s.ex_branch = 1'b1;
        s.cond = 3'd6;
        drive(s);
        drive(idle());
        lookup(32'h20);
        lookup(32'h40);

        // Randomised traffic over a few aliasing PCs
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst_n     = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            s.if_valid  = 1'($urandom_range(0, 1));
            s.if_pc     = 32'($urandom_range(0, 7)) << 2 | (32'($urandom_range(0, 3)) << 6);
            s.ex_valid  = ($urandom_range(0, 3) != 0);
            s.ex_pc     = 32'($urandom_range(0, 7)) << 2 | (32'($urandom_range(0, 3)) << 6);
            s.ex_branch = ($urandom_range(0, 3) != 0);
            s.ex_jump   = ($urandom_range(0, 5) == 0);
            s.cond      = 3'($urandom_range(0, 7));
            s.sign      = int'($urandom_range(0, 2)) - 1;
            s.ex_pred   = 1'($urandom_range(0, 1));
            drive(s);
        end
        drive(idle());

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/branch_predict_judge.md
Name: branch_predict_judge

Overview:
Parametrised successor to the single-bit branch decision block. It resolves branch and jump outcomes in EX against a generalised condition code, and keeps a PC-indexed table of 2-bit saturating counters. The table supplies a registered taken/not-taken prediction to IF, and the block flags mispredictions for pipeline flush. Saturating statistics counters support performance checks in simulation.

Parameters:
PC_WIDTH, 32, width of program-counter inputs
ENTRIES, 16, branch history table depth; power of two, 2..256
INDEX_LSB, 2, lowest PC bit used for the table index (word-aligned PCs)
PREDICT_MODE, 1, 0 = static not-taken (table frozen, prediction always 0); 1 = dynamic 2-bit
CNT_WIDTH, 16, width of statistics counters

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
if_valid  in  1  IF-stage lookup request
if_pc  in  PC_WIDTH  PC of the fetched instruction
pred_valid  out  1  prediction valid, one cycle after if_valid
pred_taken  out  1  predicted direction for the PC latched last cycle
ex_valid  in  1  EX-stage instruction valid
ex_pc  in  PC_WIDTH  PC of the instruction in EX
ex_branch  in  1  instruction is a conditional branch
ex_jump  in  1  instruction is an unconditional jump
ex_cond  in  3  branch condition code
zero  in  1  compared operand equals zero (EQ/NE: operands equal)
positive  in  1  compared operand strictly greater than zero
ex_pred_taken  in  1  prediction carried down the pipe with this instruction
out  out  1  resolved taken, registered
mispredict  out  1  one-cycle pulse; resolved direction differs from ex_pred_taken
branch_count  out  CNT_WIDTH  resolved branches plus jumps, saturating
mispredict_count  out  CNT_WIDTH  mispredictions, saturating

Behaviour:
- Reset (rst_n=0 at a clock edge): pred_valid, pred_taken, out and mispredict go to 0. Both counters go to 0. Every table entry goes to 2'b01 (weakly not-taken) in that same cycle. Reset overrides any concurrent lookup or update.
- Index: idx = pc[INDEX_LSB +: log2(ENTRIES)]. Higher PC bits are ignored, so aliasing is permitted.
- Condition evaluation (combinational, feeds registers):
  - 000 EQ = zero
  - 001 NE = !zero
  - 010 LTZ = !zero & !positive
  - 011 GEZ = zero | positive
  - 100 GTZ = positive
  - 101 LEZ = !positive
  - 110 ALWAYS = 1
  - 111 NEVER = 0
- Resolution, registered with 1-cycle latency:
  - ex_valid & ex_jump: taken = 1. ex_jump takes priority over ex_branch.
  - ex_valid & ex_branch & !ex_jump: taken = condition result.
  - Otherwise: out = 0 and mispredict = 0, and no table or counter change.
- mispredict: asserted next cycle when a resolved instruction has taken != ex_pred_taken. It is high for exactly one cycle per mispredicted instruction.
- Table update, dynamic mode only, on conditional branches only (jumps never update):
  - taken: counter increments, saturating at 3.
  - not taken: counter decrements, saturating at 0.
  - Update takes effect at the resolving edge.
- Prediction:
  - if_valid latches the table entry, giving pred_valid=1 and pred_taken = entry[1] the next cycle.
  - if_valid=0: pred_valid=0 next cycle and pred_taken holds its last value.
  - Static mode: pred_taken is always 0.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value (read-old). Verify explicitly.
- Counters:
  - branch_count increments per resolved branch or jump.
  - mispredict_count increments per mispredict.
  - Both hold at all-ones (2^CNT_WIDTH-1) and never wrap.
- Reset during a pending resolution: the result is discarded, with no pulse and no count after reset.
- Inputs other than rst_n are don't-care while ex_valid=0 / if_valid=0.

Test Plan:
1. Reset, then if_valid with if_pc=0x40 -> next cycle pred_valid=1, pred_taken=0 (entry 01). Repeat for idx 0..ENTRIES-1 -> all 0.
2. Three resolved taken branches at ex_pc=0x40 (cond=EQ, zero=1, ex_pred_taken=0):
   - out=1 each cycle.
   - mispredict=1 on all three.
   - Entry walks 01→10→11→11.
   - A following lookup at 0x40 gives pred_taken=1.
   - mispredict_count=3, branch_count=3.
3. Condition sweep at cond 000..111 with (zero,positive) in {(1,0),(0,1),(0,0)} -> out matches the table above, e.g. cond=010 with (0,0) gives 1 and cond=100 with (1,0) gives 0.
4. ex_jump=1 with ex_branch=1, cond=NEVER, ex_pred_taken=1 -> out=1, mispredict=0, table entry unchanged, branch_count+1.
5. Same-cycle lookup and update of idx 5 (entry 01, taken update) -> pred_taken=0 (old value); next lookup gives 1. Run with PREDICT_MODE=0 -> pred_taken stays 0 and the entry is never modified.
6. CNT_WIDTH=4: 20 mispredicted branches -> counters saturate at 15. Assert rst_n=0 with a branch resolving in the same cycle -> no out/mispredict pulse next cycle, counters 0, entries back to 01.
